// File: rtl/usb_ctl_responder.sv
// rtl/usb_ctl_responder.sv - endpoint-0 standard-request engine with descriptor ROM streaming
module usb_ctl_responder #(
    parameter int ROM_AW   = 6,
    parameter int DEV_BASE = 0,
    parameter int DEV_LEN  = 18,
    parameter int CFG_BASE = 18,
    parameter int CFG_LEN  = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ctl_start,
    input  logic [3:0]        ctl_endpoint,
    input  logic [7:0]        ctl_request_type,
    input  logic [7:0]        ctl_request,
    input  logic [15:0]       ctl_value,
    input  logic [15:0]       ctl_index,
    input  logic [15:0]       ctl_length,
    input  logic              ctl_done,
    output logic              rom_en,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [7:0]        xfer_tx_tdata,
    output logic              xfer_tx_tlast,
    output logic              xfer_tx_tvalid,
    input  logic              xfer_tx_tready,
    input  logic [7:0]        xfer_rx_tdata,
    input  logic              xfer_rx_tlast,
    input  logic              xfer_rx_tvalid,
    output logic              xfer_rx_tready,
    output logic              req_stall,
    output logic [6:0]        device_addr,
    output logic              configured
);
    localparam logic [2:0] S_IDLE = 3'd0, S_DECODE = 3'd1, S_PRIME = 3'd2,
                           S_SEND = 3'd3, S_SINK = 3'd4, S_WAIT = 3'd5;
    localparam logic [1:0] K_NONE = 2'd0, K_ADDR = 2'd1, K_CFG = 2'd2;

    logic [2:0]        state_q, state_d;
    logic [3:0]        ep_q, ep_d;
    logic [7:0]        rtype_q, rtype_d, req_q, req_d;
    logic [15:0]       value_q, value_d, length_q, length_d;
    logic              stall_q, stall_d, cfg_q, cfg_d, pend_cfg_q, pend_cfg_d;
    logic [6:0]        dev_addr_q, dev_addr_d, pend_addr_q, pend_addr_d;
    logic [1:0]        kind_q, kind_d, fifo_cnt_q, fifo_cnt_d;
    logic [ROM_AW-1:0] addr_q, addr_d;
    logic [15:0]       issue_left_q, issue_left_d, remain_q, remain_d;
    logic              inflight_q, inflight_d, out_valid_q, out_valid_d;
    logic [7:0]        fifo0_q, fifo0_d, fifo1_q, fifo1_d, out_data_q, out_data_d;

    logic              rom_en_c, fire, load, push, pop, issue;
    logic [ROM_AW-1:0] rom_addr_c, dec_base;
    logic [15:0]       dec_len, dec_cnt;
    logic              unused_ok;

    assign unused_ok = ^{ctl_index, xfer_rx_tdata};

    always_comb begin
        state_d = state_q;  ep_d = ep_q;  rtype_d = rtype_q;  req_d = req_q;
        value_d = value_q;  length_d = length_q;  stall_d = stall_q;  cfg_d = cfg_q;
        pend_cfg_d = pend_cfg_q;  dev_addr_d = dev_addr_q;  pend_addr_d = pend_addr_q;
        kind_d = kind_q;  fifo_cnt_d = fifo_cnt_q;  addr_d = addr_q;
        issue_left_d = issue_left_q;  remain_d = remain_q;  inflight_d = inflight_q;
        out_valid_d = out_valid_q;  fifo0_d = fifo0_q;  fifo1_d = fifo1_q;  out_data_d = out_data_q;
        rom_en_c = 1'b0;  rom_addr_c = addr_q;
        load = 1'b0;  push = 1'b0;  pop = 1'b0;  issue = 1'b0;
        fire = out_valid_q & xfer_tx_tready;
        dec_len  = (value_q[15:8] == 8'd1) ? 16'(DEV_LEN) : 16'(CFG_LEN);
        dec_base = (value_q[15:8] == 8'd1) ? ROM_AW'(DEV_BASE) : ROM_AW'(CFG_BASE);
        dec_cnt  = (length_q < dec_len) ? length_q : dec_len;

        case (state_q)
            S_DECODE: begin
                kind_d = K_NONE;
                if (ep_q != 4'd0) begin
                    stall_d = 1'b1;
                    state_d = S_IDLE;
                end else if (rtype_q == 8'h80 && req_q == 8'h06 &&
                             (value_q[15:8] == 8'd1 || value_q[15:8] == 8'd2)) begin
                    remain_d = dec_cnt;
                    if (dec_cnt == 16'd0) begin
                        state_d = S_WAIT;
                    end else begin
                        // first ROM read goes out here so PRIME can capture it
                        rom_en_c     = 1'b1;
                        rom_addr_c   = dec_base;
                        addr_d       = dec_base + ROM_AW'(1);
                        issue_left_d = dec_cnt - 16'd1;
                        inflight_d   = 1'b1;
                        state_d      = S_PRIME;
                    end
                end else if (rtype_q == 8'h00 && req_q == 8'h05) begin
                    pend_addr_d = value_q[6:0];
                    kind_d      = K_ADDR;
                    state_d     = S_WAIT;
                end else if (rtype_q == 8'h00 && req_q == 8'h09) begin
                    pend_cfg_d = |value_q[7:0];
                    kind_d     = K_CFG;
                    state_d    = S_WAIT;
                end else if (!rtype_q[7] && length_q != 16'd0) begin
                    state_d = S_SINK;
                end else begin
                    stall_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_PRIME, S_SEND: begin
                load = !out_valid_q | fire;
                if (load) begin
                    if (fifo_cnt_q != 2'd0) begin
                        out_data_d  = fifo0_q;
                        out_valid_d = 1'b1;
                        pop         = 1'b1;
                    end else if (inflight_q) begin
                        out_data_d  = rom_data;
                        out_valid_d = 1'b1;
                    end else begin
                        out_valid_d = 1'b0;
                    end
                end
                push = inflight_q & !(load & (fifo_cnt_q == 2'd0));
                case ({push, pop})
                    2'b10: begin
                        if (fifo_cnt_q == 2'd0) fifo0_d = rom_data;
                        else                    fifo1_d = rom_data;
                        fifo_cnt_d = fifo_cnt_q + 2'd1;
                    end
                    2'b01: begin
                        fifo0_d    = fifo1_q;
                        fifo_cnt_d = fifo_cnt_q - 2'd1;
                    end
                    2'b11: begin
                        if (fifo_cnt_q == 2'd1) begin
                            fifo0_d = rom_data;
                        end else begin
                            fifo0_d = fifo1_q;
                            fifo1_d = rom_data;
                        end
                    end
                    default: ;
                endcase
                // skid holds at most two bytes counting the read in flight
                issue = (issue_left_q != 16'd0) && ((fifo_cnt_q + {1'b0, inflight_q}) < 2'd2);
                if (issue) begin
                    rom_en_c     = 1'b1;
                    addr_d       = addr_q + ROM_AW'(1);
                    issue_left_d = issue_left_q - 16'd1;
                end
                inflight_d = issue;
                if (fire) begin
                    remain_d = remain_q - 16'd1;
                    if (remain_q == 16'd1) begin
                        out_valid_d = 1'b0;
                        state_d     = S_WAIT;
                    end
                end
                if (state_q == S_PRIME) state_d = S_SEND;
            end
            S_SINK: begin
                if (xfer_rx_tvalid && xfer_rx_tlast) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (ctl_done) begin
                    if (kind_q == K_ADDR) dev_addr_d = pend_addr_q;
                    if (kind_q == K_CFG)  cfg_d      = pend_cfg_q;
                    state_d = S_IDLE;
                end
            end
            default: ;
        endcase

        if (ctl_start) begin
            ep_d = ctl_endpoint;  rtype_d = ctl_request_type;  req_d = ctl_request;
            value_d = ctl_value;  length_d = ctl_length;
            stall_d = 1'b0;  state_d = S_DECODE;
            out_valid_d = 1'b0;  fifo_cnt_d = 2'd0;  inflight_d = 1'b0;  rom_en_c = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;  ep_q <= '0;  rtype_q <= '0;  req_q <= '0;
            value_q <= '0;  length_q <= '0;  stall_q <= 1'b0;  cfg_q <= 1'b0;
            pend_cfg_q <= 1'b0;  dev_addr_q <= '0;  pend_addr_q <= '0;  kind_q <= K_NONE;
            fifo_cnt_q <= '0;  addr_q <= '0;  issue_left_q <= '0;  remain_q <= '0;
            inflight_q <= 1'b0;  out_valid_q <= 1'b0;  fifo0_q <= '0;  fifo1_q <= '0;
            out_data_q <= '0;
        end else begin
            state_q <= state_d;  ep_q <= ep_d;  rtype_q <= rtype_d;  req_q <= req_d;
            value_q <= value_d;  length_q <= length_d;  stall_q <= stall_d;  cfg_q <= cfg_d;
            pend_cfg_q <= pend_cfg_d;  dev_addr_q <= dev_addr_d;  pend_addr_q <= pend_addr_d;
            kind_q <= kind_d;  fifo_cnt_q <= fifo_cnt_d;  addr_q <= addr_d;
            issue_left_q <= issue_left_d;  remain_q <= remain_d;  inflight_q <= inflight_d;
            out_valid_q <= out_valid_d;  fifo0_q <= fifo0_d;  fifo1_q <= fifo1_d;
            out_data_q <= out_data_d;
        end
    end

    assign rom_en         = rom_en_c;
    assign rom_addr       = rom_en_c ? rom_addr_c : '0;
    assign xfer_tx_tdata  = out_data_q;
    assign xfer_tx_tvalid = out_valid_q;
    assign xfer_tx_tlast  = out_valid_q & (remain_q == 16'd1);
    assign xfer_rx_tready = (state_q == S_SINK);
    assign req_stall      = stall_q;
    assign device_addr    = dev_addr_q;
    assign configured     = cfg_q;
endmodule
